prep3_stim_gen: RTL and testbench
=================================

PREP3_STIM_GEN -- requirements
Module: prep3_stim_gen

Interface
REQ-001 Parameter FILL, default 8'h00: don't-care byte sent in states SC, SD, SE, SF and SG.
REQ-002 Parameter HOLD, default 8'h77: byte that keeps the receiver in SA; SHALL NOT be 8'h2a, 8'h1f or 8'h3c.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a run.
REQ-006 path  input  2  selects the state-machine path; sampled when start is accepted.
REQ-007 reps  input  8  number of back-to-back path repetitions; sampled with start; 0 is treated as 1.
REQ-008 abort  input  1  synchronous cancel of the current run.
REQ-009 tx_ready  input  1  downstream ready (byte sink).
REQ-010 tx_data  output  8  stimulus byte for the receiver's in port.
REQ-011 tx_valid  output  1  tx_data is valid.
REQ-012 exp_out  output  8  expected receiver out code for the current tx_data.
REQ-013 busy  output  1  high while a run is active.
REQ-014 done  output  1  one-cycle pulse when a run completes normally.

Function
REQ-015 Path byte sequences SHALL be:
- path 0: 3c,2a,FILL,FILL,FILL
- path 1: 3c,1f,aa,FILL
- path 2: 3c,1f,55,FILL,FILL
- path 3: 3c,HOLD,HOLD,2a,FILL,FILL,FILL
REQ-016 Matching exp_out sequences SHALL be:
- path 0: 82,40,08,80,01
- path 1: 82,20,11,40
- path 2: 82,20,30,02,01
- path 3: 82,04,04,40,08,80,01
REQ-017 The FSM SHALL have the states IDLE and RUN.
REQ-018 In IDLE, start=1 SHALL latch path, set the repetition counter to max(reps,1) and set the index to 0, then enter RUN on the next cycle.
REQ-019 In RUN, tx_valid SHALL be 1, and tx_data and exp_out SHALL be the table entries for the latched path at the current index.
REQ-020 A byte SHALL transfer only on a cycle with tx_valid=1 and tx_ready=1; with tx_ready=0, tx_data and exp_out SHALL hold stable.
REQ-021 On a transfer of a non-final index, the index SHALL increment.
REQ-022 On a transfer of the final index with more repetitions left, the index SHALL return to 0 and the repetition counter SHALL decrement, with no idle cycle between repetitions.
REQ-023 On a transfer of the final index of the final repetition, the FSM SHALL enter IDLE, and done SHALL be 1 for exactly the next cycle.
REQ-024 The first byte SHALL be presented one cycle after start is accepted.
REQ-025 Each byte SHALL be presented for at least 1 cycle, with no combinational path from tx_ready to tx_valid.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 start and abort asserted together in IDLE: abort SHALL win and no run starts.
REQ-028 abort in RUN SHALL return the FSM to IDLE on the next cycle with tx_valid=0 and no done pulse, even when it coincides with a transfer.
REQ-029 busy SHALL equal (state==RUN).
REQ-030 tx_data and exp_out SHALL be 8'h00 whenever tx_valid=0.
REQ-031 The index counter SHALL be 3 bits and the repetition counter 8 bits; neither SHALL wrap beyond the table length or below 1.

Reset
REQ-032 rst=0 SHALL force, asynchronously: state=IDLE, index=0, repetition counter=0, tx_valid=0, tx_data=8'h00, exp_out=8'h00, busy=0, done=0.
REQ-033 Reset asserted mid-run SHALL discard the run with no done pulse; after release, the block SHALL wait for a new start.

Verification
REQ-034 Reset released, start with path=0, reps=1, tx_ready=1 -> tx_data 3c,2a,00,00,00 on 5 consecutive cycles; exp_out 82,40,08,80,01; done pulse on the cycle after the last byte.
REQ-035 path=1, reps=2, tx_ready=1 -> 8 bytes 3c,1f,aa,00,3c,1f,aa,00 with no gap; exactly one done pulse.
REQ-036 path=3, tx_ready toggling 1,0,1,0 -> every byte held while tx_ready=0; full sequence 3c,77,77,2a,00,00,00 delivered in order; no byte duplicated or dropped.
REQ-037 path=2, reps=0 -> single run 3c,1f,55,00,00 with exp_out 82,20,30,02,01.
REQ-038 abort at index 2 of path 0 -> tx_valid=0 on the next cycle, busy=0, no done pulse; a following start runs the complete path.
REQ-039 rst pulsed low mid-run on path 1 -> all outputs 0 immediately; start asserted while busy is ignored; closed-loop run against the PREP3 receiver returns it to START with out matching exp_out one cycle after each transfer.

Source files
------------

// File: rtl/prep3_stim_gen_if.sv
// Byte-stream link from the PREP3 stimulus generator to the receiver under test,
// carrying the stimulus byte and the receiver output code it should produce.
interface prep3_stim_gen_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] exp_out;

    modport master (output tx_data, output tx_valid, output exp_out, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input exp_out, output tx_ready);
endinterface

// File: rtl/prep3_stim_gen.sv
// Stimulus generator that walks the PREP3 receiver along one of four state paths,
// emitting each input byte together with the out code the receiver should produce.
module prep3_stim_gen #(
    parameter logic [7:0] FILL = 8'h00,
    parameter logic [7:0] HOLD = 8'h77
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        path,
    input  logic [7:0]        reps,
    input  logic              abort,
    prep3_stim_gen_if.master  tx,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [1:0] path_q, path_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] rep_q, rep_d;
    logic       done_q, done_d;

    logic [2:0] last_idx;
    logic [7:0] data_tbl;
    logic [7:0] exp_tbl;
    logic       run;
    logic       xfer;

    assign run  = (state_q == RUN);
    assign xfer = run && tx.tx_ready;

    // Sequence tables: receiver input byte and expected out code per path and index
    always_comb begin
        last_idx = 3'd0;
        data_tbl = 8'h00;
        exp_tbl  = 8'h00;
        case (path_q)
            2'd0: begin
                last_idx = 3'd4;
                case (idx_q)
                    3'd0:    begin data_tbl = 8'h3c; exp_tbl = 8'h82; end
                    3'd1:    begin data_tbl = 8'h2a; exp_tbl = 8'h40; end
                    3'd2:    begin data_tbl = FILL;  exp_tbl = 8'h08; end
                    3'd3:    begin data_tbl = FILL;  exp_tbl = 8'h80; end
                    3'd4:    begin data_tbl = FILL;  exp_tbl = 8'h01; end
                    default: begin data_tbl = 8'h00; exp_tbl = 8'h00; end
                endcase
            end
            2'd1: begin
                last_idx = 3'd3;
                case (idx_q)
                    3'd0:    begin data_tbl = 8'h3c; exp_tbl = 8'h82; end
                    3'd1:    begin data_tbl = 8'h1f; exp_tbl = 8'h20; end
                    3'd2:    begin data_tbl = 8'haa; exp_tbl = 8'h11; end
                    3'd3:    begin data_tbl = FILL;  exp_tbl = 8'h40; end
                    default: begin data_tbl = 8'h00; exp_tbl = 8'h00; end
                endcase
            end
            2'd2: begin
                last_idx = 3'd4;
                case (idx_q)
                    3'd0:    begin data_tbl = 8'h3c; exp_tbl = 8'h82; end
                    3'd1:    begin data_tbl = 8'h1f; exp_tbl = 8'h20; end
                    3'd2:    begin data_tbl = 8'h55; exp_tbl = 8'h30; end
                    3'd3:    begin data_tbl = FILL;  exp_tbl = 8'h02; end
                    3'd4:    begin data_tbl = FILL;  exp_tbl = 8'h01; end
                    default: begin data_tbl = 8'h00; exp_tbl = 8'h00; end
                endcase
            end
            default: begin
                last_idx = 3'd6;
                case (idx_q)
                    3'd0:    begin data_tbl = 8'h3c; exp_tbl = 8'h82; end
                    3'd1:    begin data_tbl = HOLD;  exp_tbl = 8'h04; end
                    3'd2:    begin data_tbl = HOLD;  exp_tbl = 8'h04; end
                    3'd3:    begin data_tbl = 8'h2a; exp_tbl = 8'h40; end
                    3'd4:    begin data_tbl = FILL;  exp_tbl = 8'h08; end
                    3'd5:    begin data_tbl = FILL;  exp_tbl = 8'h80; end
                    3'd6:    begin data_tbl = FILL;  exp_tbl = 8'h01; end
                    default: begin data_tbl = 8'h00; exp_tbl = 8'h00; end
                endcase
            end
        endcase
    end

    // Abort outranks both a start request and an in-flight transfer
    always_comb begin
        state_d = state_q;
        path_d  = path_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d = 3'd0;
                if (start && !abort) begin
                    path_d  = path;
                    rep_d   = (reps == 8'd0) ? 8'd1 : reps;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else if (xfer) begin
                    if (idx_q != last_idx) begin
                        idx_d = idx_q + 3'd1;
                    end else if (rep_q > 8'd1) begin
                        idx_d = 3'd0;
                        rep_d = rep_q - 8'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            path_q  <= 2'd0;
            idx_q   <= 3'd0;
            rep_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            done_q  <= done_d;
        end
    end

    // Outputs depend only on registered state, so tx_ready never reaches tx_valid
    assign tx.tx_valid = run;
    assign tx.tx_data  = run ? data_tbl : 8'h00;
    assign tx.exp_out  = run ? exp_tbl : 8'h00;
    assign busy        = run;
    assign done        = done_q;

endmodule

// File: tb/tb_prep3_stim_gen.sv
// Self-checking bench for prep3_stim_gen: directed and randomized runs compared
// against a byte-queue model built from the path tables.
module tb_prep3_stim_gen;

    localparam logic [7:0] FILL = 8'h00;
    localparam logic [7:0] HOLD = 8'h77;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] path;
    logic [7:0] reps;
    logic       abort;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    prep3_stim_gen_if tx_if ();

    prep3_stim_gen #(.FILL(FILL), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .path  (path),
        .reps  (reps),
        .abort (abort),
        .tx    (tx_if),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected byte stream of a whole run: the path table repeated max(reps,1) times
    function automatic void buildExpected(input int p, input int r);
        logic [55:0] dat;
        logic [55:0] ex;
        int len;
        int n;
        case (p)
            0: begin
                dat = {8'h3c, 8'h2a, FILL, FILL, FILL, 16'h0};
                ex  = {8'h82, 8'h40, 8'h08, 8'h80, 8'h01, 16'h0};
                len = 5;
            end
            1: begin
                dat = {8'h3c, 8'h1f, 8'haa, FILL, 24'h0};
                ex  = {8'h82, 8'h20, 8'h11, 8'h40, 24'h0};
                len = 4;
            end
            2: begin
                dat = {8'h3c, 8'h1f, 8'h55, FILL, FILL, 16'h0};
                ex  = {8'h82, 8'h20, 8'h30, 8'h02, 8'h01, 16'h0};
                len = 5;
            end
            default: begin
                dat = {8'h3c, HOLD, HOLD, 8'h2a, FILL, FILL, FILL};
                ex  = {8'h82, 8'h04, 8'h04, 8'h40, 8'h08, 8'h80, 8'h01};
                len = 7;
            end
        endcase
        n = (r < 1) ? 1 : r;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({dat[55-8*i -: 8], ex[55-8*i -: 8]});
            end
        end
    endfunction

    // ready_mode: 0 always ready, 1 alternating 1/0, 2 random
    task automatic applyStimulus(input int p, input int r, input int ready_mode, input bit poke_start);
        int          cyc;
        logic        rdy;
        logic        held;
        logic [7:0]  held_data;
        logic [7:0]  held_exp;
        logic [15:0] e;
        buildExpected(p, r);
        start = 1'b1;
        path  = p[1:0];
        reps  = r[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("first_valid", 32'(tx_if.tx_valid), 32'd1);
        held = 1'b0;
        cyc  = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            if (held) begin
                checkOutput("hold_data", 32'(tx_if.tx_data), 32'(held_data));
                checkOutput("hold_exp", 32'(tx_if.exp_out), 32'(held_exp));
            end
            checkOutput("valid_in_run", 32'(tx_if.tx_valid), 32'd1);
            checkOutput("busy_in_run", 32'(busy), 32'd1);
            checkOutput("no_early_done", 32'(done), 32'd0);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_if.tx_ready = rdy;
            if (poke_start) begin
                start = (cyc == 2);
                path  = p[1:0] + 2'd1;
                reps  = 8'd5;
            end
            if (rdy) begin
                e = exp_q.pop_front();
                checkOutput("tx_data", 32'(tx_if.tx_data), 32'(e[15:8]));
                checkOutput("exp_out", 32'(tx_if.exp_out), 32'(e[7:0]));
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = tx_if.tx_data;
                held_exp  = tx_if.exp_out;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        tx_if.tx_ready = 1'b0;
        checkOutput("all_bytes_sent", 32'(exp_q.size()), 32'd0);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("idle_valid", 32'(tx_if.tx_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_data", 32'(tx_if.tx_data), 32'd0);
        checkOutput("idle_exp", 32'(tx_if.exp_out), 32'd0);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        path  = 2'd0;
        reps  = 8'd0;
        abort = 1'b0;
        tx_if.tx_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(tx_if.tx_valid), 32'd0);
        checkOutput("rst_data", 32'(tx_if.tx_data), 32'd0);
        checkOutput("rst_exp", 32'(tx_if.exp_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] path 0 single run, always ready");
        applyStimulus(0, 1, 0, 1'b0);
        $display("[TB] path 1 two reps back to back");
        applyStimulus(1, 2, 0, 1'b0);
        $display("[TB] path 3 with alternating ready");
        applyStimulus(3, 1, 1, 1'b0);
        $display("[TB] path 2 with reps=0");
        applyStimulus(2, 0, 0, 1'b0);

        $display("[TB] abort at index 2 of path 0");
        start = 1'b1; path = 2'd0; reps = 8'd1; tx_if.tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_at_idx2", 32'(tx_if.exp_out), 32'h08);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_valid", 32'(tx_if.tx_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_data", 32'(tx_if.tx_data), 32'd0);
        @(posedge clk); #1;
        checkOutput("abort_no_late_done", 32'(done), 32'd0);
        applyStimulus(0, 1, 0, 1'b0);

        $display("[TB] start and abort together in idle");
        start = 1'b1; abort = 1'b1; path = 2'd1; reps = 8'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        checkOutput("start_abort_valid", 32'(tx_if.tx_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("start_abort_still_idle", 32'(busy), 32'd0);

        $display("[TB] reset mid-run on path 1");
        start = 1'b1; path = 2'd1; reps = 8'd3; tx_if.tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(tx_if.tx_valid), 32'd0);
        checkOutput("async_rst_data", 32'(tx_if.tx_data), 32'd0);
        checkOutput("async_rst_exp", 32'(tx_if.exp_out), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_idle", 32'(busy), 32'd0);
        checkOutput("post_rst_no_done", 32'(done), 32'd0);
        tx_if.tx_ready = 1'b0;

        $display("[TB] start while busy is ignored");
        applyStimulus(3, 1, 0, 1'b1);

        $display("[TB] randomized runs");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
